full_adder: RTL and testbench

Single-bit (width-parameterisable) binary full adder used as the basic arithmetic cell of the datapath. It provides a purely combinational sum/carry path for ripple chains. Alongside it runs a clocked, valid-qualified registered copy of the result for pipelined users, plus a saturating carry-event counter for debug visibility.

---
 rtl/full_adder.sv | 67 ++++++
 tb/tb_full_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Full adder cell with ripple carry chain for WIDTH > 1.
// Also provides a registered, valid-qualified copy of the result.
//
// Ports:
//   sum, carry   combinational a + b + cin (never reset)
//   a, b, cin    operands and carry-in
//   clk, rst_n   clock and synchronous active-low reset (registered path only)
//   in_valid     capture request for the registered path
//   sum_q        registered sum
//   carry_q      registered carry
//   out_valid    one-cycle pulse per captured result
//   carry_cnt    saturating count of captures with carry=1
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic p;
        assign p        = a[i] ^ b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
    end

    assign carry = c[WIDTH];

    // Counter stops at all-ones so debug reads never see a wrapped value.
    logic cnt_full;
    assign cnt_full = &carry_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else if (in_valid) begin
            sum_q     <= sum;
            carry_q   <= carry;
            out_valid <= 1'b1;
            if (carry && !cnt_full) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder.
// Covers WIDTH=1 truth table, registered path, saturation and WIDTH=4.
module tb_full_adder;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic a, b, cin;
    logic sum, carry;
    logic sum_q, carry_q, out_valid;
    logic [15:0] carry_cnt;

    logic s_sum, s_carry, s_sum_q, s_carry_q, s_out_valid;
    logic [1:0] s_cnt;

    logic [3:0] a4, b4;
    logic cin4, in_valid4;
    logic [3:0] sum4, sum4_q;
    logic carry4, carry4_q, out_valid4;
    logic [15:0] cnt4;

    int errors = 0;
    int checks = 0;

    full_adder #(.WIDTH(1), .CNT_W(16)) u1 (
        .sum(sum), .carry(carry), .a(a), .b(b), .cin(cin),
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .sum_q(sum_q), .carry_q(carry_q), .out_valid(out_valid),
        .carry_cnt(carry_cnt)
    );

    full_adder #(.WIDTH(1), .CNT_W(2)) u_sat (
        .sum(s_sum), .carry(s_carry), .a(a), .b(b), .cin(cin),
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .sum_q(s_sum_q), .carry_q(s_carry_q), .out_valid(s_out_valid),
        .carry_cnt(s_cnt)
    );

    full_adder #(.WIDTH(4), .CNT_W(16)) u4 (
        .sum(sum4), .carry(carry4), .a(a4), .b(b4), .cin(cin4),
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
        .sum_q(sum4_q), .carry_q(carry4_q), .out_valid(out_valid4),
        .carry_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp; // {carry, sum}
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
    } vec4_t;

    vec1_t tt[8];
    vec4_t t4[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        tt[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        tt[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        tt[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        tt[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        tt[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        tt[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        tt[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        t4[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        t4[1] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        t4[2] = '{4'h5, 4'h2, 1'b0, 4'h7, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

        // Combinational truth table, 5 ns per vector.
        for (int i = 0; i < 8; i++) begin
            a = tt[i].a; b = tt[i].b; cin = tt[i].cin;
            #5;
            chk($sformatf("tt%0d", i), {30'd0, carry, sum},
                {30'd0, tt[i].exp});
        end

        // WIDTH=4 ripple chain.
        for (int i = 0; i < 3; i++) begin
            a4 = t4[i].a; b4 = t4[i].b; cin4 = t4[i].cin;
            #5;
            chk($sformatf("w4_sum%0d", i), {28'd0, sum4},
                {28'd0, t4[i].s});
            chk($sformatf("w4_carry%0d", i), {31'd0, carry4},
                {31'd0, t4[i].co});
        end

        // Reset for two cycles.
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_sum_q", {31'd0, sum_q}, 32'd0);
        chk("rst_carry_q", {31'd0, carry_q}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", {16'd0, carry_cnt}, 32'd0);

        // Single capture of 1+1+0.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        a = 1'b1; b = 1'b1; cin = 1'b0;
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        chk("cap_sum_q", {31'd0, sum_q}, 32'd0);
        chk("cap_carry_q", {31'd0, carry_q}, 32'd1);
        chk("cap_out_valid", {31'd0, out_valid}, 32'd1);
        chk("cap_cnt", {16'd0, carry_cnt}, 32'd1);
        chk("w4_sum_q", {28'd0, sum4_q}, 32'd0);
        chk("w4_carry_q", {31'd0, carry4_q}, 32'd1);

        // Drop in_valid: pulse ends, data holds.
        @(negedge clk);
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        a = 1'b0; b = 1'b0;
        a4 = 4'h5; b4 = 4'h2;
        tick();
        chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_sum_q", {31'd0, sum_q}, 32'd0);
        chk("hold_carry_q", {31'd0, carry_q}, 32'd1);
        chk("hold_cnt", {16'd0, carry_cnt}, 32'd1);
        chk("w4_hold_sum_q", {28'd0, sum4_q}, 32'd0);

        // Reset beats in_valid.
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 1'b1; b = 1'b1; cin = 1'b1;
        #1;
        chk("prio_comb_sum", {31'd0, sum}, 32'd1);
        chk("prio_comb_carry", {31'd0, carry}, 32'd1);
        tick();
        chk("prio_sum_q", {31'd0, sum_q}, 32'd0);
        chk("prio_carry_q", {31'd0, carry_q}, 32'd0);
        chk("prio_out_valid", {31'd0, out_valid}, 32'd0);
        chk("prio_cnt", {16'd0, carry_cnt}, 32'd0);

        // Back-to-back over all vectors.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            in_valid = 1'b1;
            a = tt[i].a; b = tt[i].b; cin = tt[i].cin;
            tick();
            chk($sformatf("b2b_res%0d", i), {30'd0, carry_q, sum_q},
                {30'd0, tt[i].exp});
            chk($sformatf("b2b_vld%0d", i), {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        chk("b2b_cnt", {16'd0, carry_cnt}, 32'd4);
        chk("b2b_end_vld", {31'd0, out_valid}, 32'd0);
        chk("b2b_end_hold", {30'd0, carry_q, sum_q}, 32'd3);

        // Saturation with a 2-bit counter.
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("sat_rst", {30'd0, s_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            in_valid = 1'b1;
            a = 1'b1; b = 1'b1; cin = 1'b0;
            tick();
            chk($sformatf("sat_cnt%0d", i), {30'd0, s_cnt},
                (i < 3) ? i + 1 : 3);
        end
        chk("wide_cnt", {16'd0, carry_cnt}, 32'd5);

        @(negedge clk);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
